// File: rtl/wb_csr_commit_pkg.sv
// rtl/wb_csr_commit_pkg.sv - commit op encodings, exception codes and FSM states for wb_csr_commit
package wb_csr_commit_pkg;

    localparam logic [3:0] WOP_NONE    = 4'd0;
    localparam logic [3:0] WOP_CSRRD   = 4'd1;
    localparam logic [3:0] WOP_CSRWR   = 4'd2;
    localparam logic [3:0] WOP_CSRXCHG = 4'd3;
    localparam logic [3:0] WOP_ERTN    = 4'd4;
    localparam logic [3:0] WOP_SYSCALL = 4'd5;
    localparam logic [3:0] WOP_BREAK   = 4'd6;
    localparam logic [3:0] WOP_RDCNTVL = 4'd7;
    localparam logic [3:0] WOP_RDCNTVH = 4'd8;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

endpackage

// File: rtl/wb_csr_commit_stable_counter.sv
// rtl/wb_csr_commit_stable_counter.sv - free-running 64-bit stable counter, wraps on overflow
module wb_csr_commit_stable_counter (
    input  logic        clk,
    input  logic        resetn,
    output logic [63:0] cnt
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= 64'd0;
        end else begin
            cnt <= cnt + 64'd1;
        end
    end

endmodule

// File: rtl/wb_csr_commit.sv
// rtl/wb_csr_commit.sv - WB commit unit driving the CSR port, flush/redirect and rf write-back
// Optional feature: WB_STABLE_CNT_EN enables RDCNTVL/RDCNTVH via the stable counter.
module wb_csr_commit
    import wb_csr_commit_pkg::*;
#(
    parameter int PC_W     = 32,
    parameter int CSRNUM_W = 14
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PC_W-1:0]     in_pc,
    input  logic [3:0]          in_op,
    input  logic [CSRNUM_W-1:0] in_csr_num,
    input  logic [31:0]         in_rj,
    input  logic [31:0]         in_rd,
    input  logic [4:0]          in_dest,
    input  logic [31:0]         in_result,
    input  logic                in_ex,
    input  logic [5:0]          in_ecode,
    input  logic [8:0]          in_esubcode,
    input  logic [PC_W-1:0]     in_vaddr,
    output logic                csr_re,
    output logic                csr_we,
    output logic [CSRNUM_W-1:0] csr_num,
    output logic [31:0]         csr_wmask,
    output logic [31:0]         csr_wvalue,
    input  logic [31:0]         csr_rvalue,
    output logic                wb_ex,
    output logic                ertn_flush,
    output logic [PC_W-1:0]     wb_csr_pc,
    output logic [PC_W-1:0]     wb_vaddr,
    output logic [5:0]          wb_ecode,
    output logic [8:0]          wb_esubcode,
    input  logic [PC_W-1:0]     ex_entry,
    input  logic [PC_W-1:0]     ertn_entry,
    input  logic                has_int,
    output logic                rf_we,
    output logic [4:0]          rf_waddr,
    output logic [31:0]         rf_wdata,
    output logic                flush,
    output logic [PC_W-1:0]     flush_target,
    input  logic                fetch_restart
);

    state_e      state, state_d;
    logic        rf_wr;
    logic [31:0] rf_val;
    logic        op_ex;
    logic [5:0]  op_ecode;

`ifdef WB_STABLE_CNT_EN
    logic [63:0] cnt;

    wb_csr_commit_stable_counter u_stable_counter (
        .clk    (clk),
        .resetn (resetn),
        .cnt    (cnt)
    );
`endif

    assign in_ready = 1'b1;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= ST_RUN;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_RUN:   if (flush) state_d = ST_DRAIN;
            ST_DRAIN: if (fetch_restart) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        csr_re       = 1'b0;
        csr_we       = 1'b0;
        csr_num      = '0;
        csr_wmask    = 32'd0;
        csr_wvalue   = 32'd0;
        wb_ex        = 1'b0;
        ertn_flush   = 1'b0;
        wb_csr_pc    = '0;
        wb_vaddr     = '0;
        wb_ecode     = 6'd0;
        wb_esubcode  = 9'd0;
        flush        = 1'b0;
        flush_target = '0;
        rf_wr        = 1'b0;
        rf_val       = 32'd0;
        op_ex        = 1'b0;
        op_ecode     = 6'd0;
        if (in_valid && in_ready && state == ST_RUN) begin
            case (in_op)
                WOP_SYSCALL: begin op_ex = 1'b1; op_ecode = ECODE_SYS; end
                WOP_BREAK:   begin op_ex = 1'b1; op_ecode = ECODE_BRK; end
`ifndef WB_STABLE_CNT_EN
                WOP_RDCNTVL, WOP_RDCNTVH: begin op_ex = 1'b1; op_ecode = ECODE_INE; end
`endif
                default: ;
            endcase
            // Interrupt outranks everything carried by the beat itself.
            if (has_int) begin
                wb_ex    = 1'b1;
                wb_ecode = ECODE_INT;
            end else if (in_ex) begin
                wb_ex       = 1'b1;
                wb_ecode    = in_ecode;
                wb_esubcode = in_esubcode;
                wb_vaddr    = in_vaddr;
            end else if (op_ex) begin
                wb_ex    = 1'b1;
                wb_ecode = op_ecode;
            end else if (in_op == WOP_ERTN) begin
                ertn_flush   = 1'b1;
                flush_target = ertn_entry;
            end else begin
                rf_wr = (in_dest != 5'd0);
                case (in_op)
                    WOP_CSRRD: begin
                        csr_re  = 1'b1;
                        csr_num = in_csr_num;
                        rf_val  = csr_rvalue;
                    end
                    WOP_CSRWR, WOP_CSRXCHG: begin
                        csr_re     = 1'b1;
                        csr_we     = 1'b1;
                        csr_num    = in_csr_num;
                        csr_wmask  = (in_op == WOP_CSRXCHG) ? in_rj : 32'hFFFF_FFFF;
                        csr_wvalue = in_rd;
                        rf_val     = csr_rvalue;
                    end
`ifdef WB_STABLE_CNT_EN
                    WOP_RDCNTVL: rf_val = cnt[31:0];
                    WOP_RDCNTVH: rf_val = cnt[63:32];
`endif
                    default: rf_val = in_result;
                endcase
            end
            if (wb_ex) begin
                wb_csr_pc    = in_pc;
                flush_target = ex_entry;
            end
            flush = wb_ex | ertn_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rf_we    <= 1'b0;
            rf_waddr <= 5'd0;
            rf_wdata <= 32'd0;
        end else begin
            rf_we <= rf_wr;
            if (rf_wr) begin
                rf_waddr <= in_dest;
                rf_wdata <= rf_val;
            end
        end
    end

endmodule

// File: tb/tb_wb_csr_commit.sv
// tb/tb_wb_csr_commit.sv - directed and randomized bench for wb_csr_commit against a rule-level model
module tb_wb_csr_commit;
    import wb_csr_commit_pkg::*;

`ifdef WB_STABLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn, in_valid, in_ready, in_ex, has_int, fetch_restart;
    logic [31:0] in_pc, in_rj, in_rd, in_result, in_vaddr, csr_rvalue, ex_entry, ertn_entry;
    logic [3:0]  in_op;
    logic [13:0] in_csr_num, csr_num;
    logic [4:0]  in_dest, rf_waddr;
    logic [5:0]  in_ecode, wb_ecode;
    logic [8:0]  in_esubcode, wb_esubcode;
    logic        csr_re, csr_we, wb_ex, ertn_flush, rf_we, flush;
    logic [31:0] csr_wmask, csr_wvalue, wb_csr_pc, wb_vaddr, rf_wdata, flush_target;

    wb_csr_commit dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_csr_num(in_csr_num), .in_rj(in_rj), .in_rd(in_rd),
        .in_dest(in_dest), .in_result(in_result), .in_ex(in_ex), .in_ecode(in_ecode),
        .in_esubcode(in_esubcode), .in_vaddr(in_vaddr), .csr_re(csr_re), .csr_we(csr_we),
        .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_csr_pc(wb_csr_pc), .wb_vaddr(wb_vaddr),
        .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .ex_entry(ex_entry), .ertn_entry(ertn_entry),
        .has_int(has_int), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .flush(flush),
        .flush_target(flush_target), .fetch_restart(fetch_restart)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    bit          m_drain = 1'b0;
    bit          m_rf_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;
    longint unsigned m_cyc = 0;

    bit          e_re, e_we, e_ex, e_ertn, e_flush, e_rf;
    logic [13:0] e_num;
    logic [31:0] e_wmask, e_wvalue, e_pc, e_vaddr, e_target, e_wdata;
    logic [5:0]  e_ecode;
    logic [8:0]  e_esub;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected commit outputs derived from the priority rules for the beat on the inputs.
    task automatic model_comb();
        longint unsigned cnt_now;
        cnt_now = m_cyc;
        {e_re, e_we, e_ex, e_ertn, e_flush, e_rf} = '0;
        e_num = '0; e_wmask = '0; e_wvalue = '0; e_pc = '0; e_vaddr = '0;
        e_target = '0; e_wdata = '0; e_ecode = '0; e_esub = '0;
        if (in_valid && !m_drain) begin
            if (has_int) begin
                e_ex = 1; e_ecode = 6'h00;
            end else if (in_ex) begin
                e_ex = 1; e_ecode = in_ecode; e_esub = in_esubcode; e_vaddr = in_vaddr;
            end else if (in_op == WOP_SYSCALL) begin
                e_ex = 1; e_ecode = 6'h0B;
            end else if (in_op == WOP_BREAK) begin
                e_ex = 1; e_ecode = 6'h0C;
            end else if (!CNT_EN && (in_op == WOP_RDCNTVL || in_op == WOP_RDCNTVH)) begin
                e_ex = 1; e_ecode = 6'h0D;
            end else if (in_op == WOP_ERTN) begin
                e_ertn = 1; e_target = ertn_entry;
            end else begin
                e_rf = (in_dest != 0);
                if (in_op == WOP_CSRRD) begin
                    e_re = 1; e_num = in_csr_num; e_wdata = csr_rvalue;
                end else if (in_op == WOP_CSRWR || in_op == WOP_CSRXCHG) begin
                    e_re = 1; e_we = 1; e_num = in_csr_num; e_wvalue = in_rd; e_wdata = csr_rvalue;
                    e_wmask = (in_op == WOP_CSRXCHG) ? in_rj : 32'hFFFF_FFFF;
                end else if (in_op == WOP_RDCNTVL) begin
                    e_wdata = cnt_now[31:0];
                end else if (in_op == WOP_RDCNTVH) begin
                    e_wdata = cnt_now[63:32];
                end else begin
                    e_wdata = in_result;
                end
            end
            if (e_ex) begin
                e_pc = in_pc; e_target = ex_entry;
            end
            e_flush = e_ex || e_ertn;
        end
    endtask

    // Called just after a negedge: check combinational outputs, clock once, check rf outputs.
    task automatic step();
        #1;
        model_comb();
        check("in_ready", in_ready, 1);
        check("csr_re", csr_re, e_re);
        check("csr_we", csr_we, e_we);
        check("csr_num", csr_num, e_num);
        check("csr_wmask", csr_wmask, e_wmask);
        check("csr_wvalue", csr_wvalue, e_wvalue);
        check("wb_ex", wb_ex, e_ex);
        check("ertn_flush", ertn_flush, e_ertn);
        check("wb_csr_pc", wb_csr_pc, e_pc);
        check("wb_vaddr", wb_vaddr, e_vaddr);
        check("wb_ecode", wb_ecode, e_ecode);
        check("wb_esubcode", wb_esubcode, e_esub);
        check("flush", flush, e_flush);
        check("flush_target", flush_target, e_target);
        @(posedge clk);
        if (!resetn) begin
            m_drain = 0; m_rf_we = 0; m_waddr = '0; m_wdata = '0; m_cyc = 0;
        end else begin
            if (!m_drain && e_flush) m_drain = 1;
            else if (m_drain && fetch_restart) m_drain = 0;
            m_rf_we = e_rf;
            if (e_rf) begin
                m_waddr = in_dest; m_wdata = e_wdata;
            end
            m_cyc++;
        end
        #1;
        check("rf_we", rf_we, m_rf_we);
        if (m_rf_we || !resetn) begin
            check("rf_waddr", rf_waddr, m_waddr);
            check("rf_wdata", rf_wdata, m_wdata);
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic [3:0] op, input logic [31:0] pc, input logic [13:0] num,
                            input logic [31:0] rj, input logic [31:0] rd, input logic [4:0] dest);
        resetn = 1; in_valid = 1; in_op = op; in_pc = pc; in_csr_num = num;
        in_rj = rj; in_rd = rd; in_dest = dest; in_ex = 0; has_int = 0; fetch_restart = 0;
    endtask

    task automatic idle();
        in_valid = 0; has_int = 0; in_ex = 0; fetch_restart = 0;
    endtask

    initial begin
        resetn = 0; in_valid = 0; in_pc = 0; in_op = 0; in_csr_num = 0; in_rj = 0; in_rd = 0;
        in_dest = 0; in_result = 0; in_ex = 0; in_ecode = 0; in_esubcode = 0; in_vaddr = 0;
        csr_rvalue = 0; ex_entry = 0; ertn_entry = 0; has_int = 0; fetch_restart = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();

        // CSRWR, then rf write-back of the old value
        set_beat(WOP_CSRWR, 32'h1C00_0000, 14'h30, 32'h0, 32'h1234, 5'd4);
        csr_rvalue = 32'hAA;
        step();
        check("csrwr_rf_wdata", rf_wdata, 32'hAA);
        // CSRXCHG with dest 0
        set_beat(WOP_CSRXCHG, 32'h1C00_0004, 14'h31, 32'h0F, 32'hFF, 5'd0);
        step();
        // SYSCALL, three discarded beats, restart with a discarded beat, then normal
        set_beat(WOP_SYSCALL, 32'h1C00_0100, 14'h0, 32'h0, 32'h0, 5'd3);
        ex_entry = 32'h1C00_8000;
        step();
        for (int i = 0; i < 3; i++) begin
            set_beat(WOP_CSRWR, 32'h1C00_0104 + 4 * i, 14'h5, 32'h1, 32'h2, 5'd7);
            step();
        end
        set_beat(WOP_NONE, 32'h1C00_0110, 14'h0, 32'h0, 32'h0, 5'd8);
        fetch_restart = 1;
        step();
        set_beat(WOP_NONE, 32'h1C00_8000, 14'h0, 32'h0, 32'h0, 5'd9);
        in_result = 32'hCAFE_0001;
        step();
        // interrupt wins over a CSRWR
        set_beat(WOP_CSRWR, 32'h1C00_8004, 14'h30, 32'h0, 32'h55, 5'd2);
        has_int = 1;
        step();
        idle(); fetch_restart = 1;
        step();
        // ERTN then reset mid-drain
        set_beat(WOP_ERTN, 32'h1C00_0200, 14'h0, 32'h0, 32'h0, 5'd0);
        ertn_entry = 32'h1C00_0204;
        step();
        idle(); resetn = 0;
        step();
        set_beat(WOP_CSRRD, 32'h1C00_0204, 14'h6, 32'h0, 32'h0, 5'd11);
        csr_rvalue = 32'h600D_0006;
        step();
        // counter read after 100 cycles out of reset
        idle(); resetn = 0;
        step();
        resetn = 1;
        repeat (100) step();
        set_beat(WOP_RDCNTVL, 32'h1C00_0300, 14'h0, 32'h0, 32'h0, 5'd12);
        if (CNT_EN) begin
            step();
            check("rdcntvl_100", rf_wdata, 32'd100);
        end else begin
            #1;
            check("rdcnt_ine", wb_ecode, 6'h0D);
            step();
            idle(); fetch_restart = 1;
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            resetn        = ($urandom_range(0, 99) >= 3);
            in_valid      = resetn && ($urandom_range(0, 3) != 0);
            in_op         = 4'($urandom_range(0, 8));
            in_pc         = $urandom;
            in_csr_num    = 14'($urandom);
            in_rj         = $urandom;
            in_rd         = $urandom;
            in_dest       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            in_result     = $urandom;
            in_ex         = ($urandom_range(0, 9) == 0);
            in_ecode      = 6'($urandom);
            in_esubcode   = 9'($urandom);
            in_vaddr      = $urandom;
            csr_rvalue    = $urandom;
            ex_entry      = $urandom;
            ertn_entry    = $urandom;
            has_int       = ($urandom_range(0, 9) == 0);
            fetch_restart = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
